pci_host_request_sequencer: RTL and testbench
=============================================

// Module: pci_host_request_sequencer
// PURPOSE
//  Upstream feeder of the Host Request FIFO (pci_fifo_storage_request, fifo_mode 2'b01, single pci_clk).
//  Accepts one burst command (address, PCI command, length, direction) plus a write-data stream.
//  Expands it into FIFO entries: one ADDRESS entry, then one entry per data phase, final entry tagged LAST.
//  The PCI Master drains these entries from the FIFO.
// PARAMETERS
//  LEN_W        4     width of cmd_len; burst length 1..2**LEN_W words, cmd_len==0 means 2**LEN_W
//  TYPE_ADDR    3'h1  request-type code of the address/command entry
//  TYPE_RD      3'h2  read data-phase entry, not last; data field = 0, cbe = byte-enables
//  TYPE_RD_LAST 3'h3  read data-phase entry, last
//  TYPE_WR      3'h4  write data-phase entry, not last; data field = write data
//  TYPE_WR_LAST 3'h5  write data-phase entry, last
// PORTS
//  pci_clk                              in   1   sole clock, all state on rising edge
//  pci_reset_l                          in   1   asynchronous reset, active low
//  cmd_valid                            in   1   command offered
//  cmd_ready                            out  1   command accepted when cmd_valid & cmd_ready
//  cmd_addr                             in   32  PCI address, low 2 bits passed through unchanged
//  cmd_pci_cmd                          in   4   PCI bus command, sent as cbe of the ADDR entry
//  cmd_is_write                         in   1   1 = write burst, 0 = read burst
//  cmd_len                              in   LEN_W  data-phase count, 0 encodes 2**LEN_W
//  cmd_rd_be_l                          in   4   byte enables (active low) for every read phase
//  wr_valid                             in   1   write data word offered
//  wr_ready                             out  1   write word consumed when wr_valid & wr_ready
//  wr_data                              in   32  write data
//  wr_be_l                              in   4   write byte enables (active low)
//  pci_host_request_room_available_meta in   1   FIFO has room for one entry this cycle
//  pci_host_request_submit              out  1   push one entry into the FIFO
//  pci_host_request_type                out  3   entry type
//  pci_host_request_cbe                 out  4   entry command / byte enables
//  pci_host_request_data                out  32  entry address / data
//  pci_host_request_error               out  1   always 0; reserved for error injection
//  burst_done                           out  1   one-cycle pulse on the cycle the LAST entry is submitted
// BEHAVIOUR
//  Reset: async on pci_reset_l low.
//   - State goes to IDLE; cmd_ready = 1.
//   - submit, wr_ready, burst_done and error = 0.
//   - type, cbe and data = 0; internal registers are cleared.
//  FSM states: IDLE, ADDR, DATA.
//   - IDLE: cmd_ready = 1. On handshake, latch addr, pci_cmd, is_write, rd_be_l, and remaining = cmd_len (0 -> 2**LEN_W).
//     Then go to ADDR. No FIFO entry is pushed in the accept cycle.
//   - ADDR: outputs are type = TYPE_ADDR, cbe = latched pci_cmd, data = latched addr.
//     submit = room_available_meta. When submitted, go to DATA.
//   - DATA, read: submit = room_available_meta. Entry is TYPE_RD or TYPE_RD_LAST, cbe = rd_be_l, data = 0.
//   - DATA, write: wr_ready = room_available_meta and submit = wr_valid & room_available_meta.
//     Entry is TYPE_WR or TYPE_WR_LAST, cbe = wr_be_l, data = wr_data. The write path is combinational, zero-latency pass-through.
//   - Each DATA submit decrements remaining. The entry is LAST when remaining == 1.
//     On the LAST submit: burst_done = 1, next state is IDLE.
//  Counter: remaining is LEN_W+1 bits wide and never wraps. Decrement happens only on submit.
//  cmd_ready = 0 outside IDLE. Back-to-back bursts therefore have one idle cycle (the accept cycle) between the LAST entry and the next ADDR.
//  Full FIFO (room low): submit = 0 and wr_ready = 0. Outputs and state hold; stalls may last any number of cycles.
//  Write underrun (wr_valid low in DATA): no submit and state holds. wr_data is ignored outside DATA.
//  Combinational outputs: type/cbe/data are combinational from state and registers, and are valid whenever submit = 1.
//   Outside ADDR/DATA they are 0. submit never depends on cmd_valid.
//  Reset mid-burst: the burst is abandoned immediately, with no further submits.
//   The FIFO is reset on the same signal by the integrator.
//  Rules:
//   - No X on any output after reset.
//   - submit is never asserted when room_available_meta = 0.
// TESTING
//  1. Read, len=1, addr=0x0000_1000, cmd=0x6, be_l=0x0, room=1.
//     -> Entries (1,6,0x1000), (3,0,0). burst_done pulses on the 2nd entry.
//  2. Write, len=3, data 0xA0..0xA2, be_l=0xF/0x0/0x3, room=1.
//     -> Entries ADDR, then (4,F,A0), (4,0,A1), (5,3,A2). wr_ready/submit occur on 3 consecutive cycles.
//  3. As test 2, but room drops low for 4 cycles after the ADDR entry.
//     -> No submit and no wr_ready during the stall. The sequence is unchanged and burst_done fires once.
//  4. Write, len=2, wr_valid gapped by 3 idle cycles.
//     -> Exactly 2 data entries are pushed, with no submit in the gaps.
//  5. cmd_len=0 with LEN_W=4, read.
//     -> 1 ADDR entry, 15 TYPE_RD entries, 1 TYPE_RD_LAST entry.
//  6. pci_reset_l pulsed low after the 2nd data entry of a len=8 write.
//     -> submit drops at once and the state returns to IDLE. A new command is accepted in the first cycle after release.

Source files
------------

// File: rtl/pci_host_request_sequencer.sv
// Burst-command expander feeding the Host Request FIFO: one ADDR entry followed by
// one entry per data phase, the final one tagged LAST. Write data passes straight through.
module pci_host_request_sequencer #(
    parameter int          LEN_W        = 4,
    parameter logic [2:0]  TYPE_ADDR    = 3'h1,
    parameter logic [2:0]  TYPE_RD      = 3'h2,
    parameter logic [2:0]  TYPE_RD_LAST = 3'h3,
    parameter logic [2:0]  TYPE_WR      = 3'h4,
    parameter logic [2:0]  TYPE_WR_LAST = 3'h5
) (
    input  logic             pci_clk,
    input  logic             pci_reset_l,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [3:0]       cmd_pci_cmd,
    input  logic             cmd_is_write,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [3:0]       cmd_rd_be_l,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_be_l,
    input  logic             pci_host_request_room_available_meta,
    output logic             pci_host_request_submit,
    output logic [2:0]       pci_host_request_type,
    output logic [3:0]       pci_host_request_cbe,
    output logic [31:0]      pci_host_request_data,
    output logic             pci_host_request_error,
    output logic             burst_done
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       pci_cmd_q, pci_cmd_d;
    logic             is_write_q, is_write_d;
    logic [3:0]       rd_be_l_q, rd_be_l_d;
    logic [LEN_W:0]   rem_q, rem_d;
    logic             last;
    logic             room;

    assign room                   = pci_host_request_room_available_meta;
    assign last                   = (rem_q == (LEN_W+1)'(1));
    assign pci_host_request_error = 1'b0;

    always_ff @(posedge pci_clk or negedge pci_reset_l) begin
        if (!pci_reset_l) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            pci_cmd_q  <= '0;
            is_write_q <= 1'b0;
            rd_be_l_q  <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            pci_cmd_q  <= pci_cmd_d;
            is_write_q <= is_write_d;
            rd_be_l_q  <= rd_be_l_d;
            rem_q      <= rem_d;
        end
    end

    always_comb begin
        state_d                 = state_q;
        addr_d                  = addr_q;
        pci_cmd_d               = pci_cmd_q;
        is_write_d              = is_write_q;
        rd_be_l_d               = rd_be_l_q;
        rem_d                   = rem_q;
        cmd_ready               = 1'b0;
        wr_ready                = 1'b0;
        burst_done              = 1'b0;
        pci_host_request_submit = 1'b0;
        pci_host_request_type   = '0;
        pci_host_request_cbe    = '0;
        pci_host_request_data   = '0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d     = cmd_addr;
                    pci_cmd_d  = cmd_pci_cmd;
                    is_write_d = cmd_is_write;
                    rd_be_l_d  = cmd_rd_be_l;
                    // a zero length encodes the maximum burst of 2**LEN_W words
                    rem_d      = (cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cmd_len};
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                pci_host_request_type   = TYPE_ADDR;
                pci_host_request_cbe    = pci_cmd_q;
                pci_host_request_data   = addr_q;
                pci_host_request_submit = room;
                if (room) state_d = DATA;
            end
            DATA: begin
                if (is_write_q) begin
                    wr_ready                = room;
                    pci_host_request_submit = wr_valid & room;
                    pci_host_request_type   = last ? TYPE_WR_LAST : TYPE_WR;
                    pci_host_request_cbe    = wr_be_l;
                    pci_host_request_data   = wr_data;
                end else begin
                    pci_host_request_submit = room;
                    pci_host_request_type   = last ? TYPE_RD_LAST : TYPE_RD;
                    pci_host_request_cbe    = rd_be_l_q;
                end
                if (pci_host_request_submit) begin
                    rem_d = rem_q - (LEN_W+1)'(1);
                    if (last) begin
                        burst_done = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pci_host_request_sequencer.sv
// Randomised bench: each burst is expanded into the expected FIFO entry list and compared
// against the entries captured at the FIFO push interface.
module tb_pci_host_request_sequencer;

    logic        pci_clk = 1'b0;
    logic        pci_reset_l;
    logic        cmd_valid, cmd_ready, cmd_is_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_pci_cmd, cmd_len, cmd_rd_be_l;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_be_l;
    logic        room, submit, req_err, burst_done;
    logic [2:0]  req_type;
    logic [3:0]  req_cbe;
    logic [31:0] req_data;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int viol_cnt = 0;

    typedef struct {
        logic        bd;
        logic [2:0]  t;
        logic [3:0]  c;
        logic [31:0] d;
        int          cyc;
    } ent_t;

    ent_t        obs[$];
    logic [31:0] wdat[$];
    logic [3:0]  wbe[$];

    pci_host_request_sequencer #(.LEN_W(4)) dut (
        .pci_clk(pci_clk), .pci_reset_l(pci_reset_l),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_pci_cmd(cmd_pci_cmd), .cmd_is_write(cmd_is_write), .cmd_len(cmd_len),
        .cmd_rd_be_l(cmd_rd_be_l), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_be_l(wr_be_l),
        .pci_host_request_room_available_meta(room),
        .pci_host_request_submit(submit), .pci_host_request_type(req_type),
        .pci_host_request_cbe(req_cbe), .pci_host_request_data(req_data),
        .pci_host_request_error(req_err), .burst_done(burst_done)
    );

    always #5 pci_clk = ~pci_clk;
    always @(posedge pci_clk) cyc_cnt <= cyc_cnt + 1;

    // capture pushed entries and flag protocol rule breaks
    always @(negedge pci_clk) begin
        if (pci_reset_l) begin
            if (submit) obs.push_back('{burst_done, req_type, req_cbe, req_data, cyc_cnt});
            if ((submit && !room) || (wr_ready && !room) || (burst_done && !submit) || req_err !== 1'b0)
                viol_cnt = viol_cnt + 1;
        end
    end

    task automatic fill_wr(input int n);
        wdat.delete(); wbe.delete();
        for (int i = 0; i < n; i++) begin
            wdat.push_back($urandom);
            wbe.push_back(4'($urandom));
        end
    endtask

    // Drive one burst, then compare the captured entries with the expected expansion.
    task automatic run_burst(input string nm, input logic wr, input logic [3:0] len,
                             input logic [31:0] addr, input logic [3:0] pcmd, input logic [3:0] rdbe,
                             input int gap, input int stall_after, input int stall_len,
                             input int room_pct, input bit chk_consec,
                             output int first_cyc, output int last_cyc);
        int   n;
        ent_t exp[$];
        int   idx, gapc, stall, subs, cyc;
        bit   accepted, done;
        n = (len == 4'd0) ? 16 : int'(len);
        exp.push_back('{1'b0, 3'h1, pcmd, addr, 0});
        for (int i = 0; i < n; i++) begin
            bit lst = (i == n - 1);
            if (wr) exp.push_back('{lst, lst ? 3'h5 : 3'h4, wbe[i], wdat[i], 0});
            else    exp.push_back('{lst, lst ? 3'h3 : 3'h2, rdbe, 32'h0, 0});
        end
        obs.delete();
        viol_cnt = 0;
        cmd_valid = 1'b1; cmd_is_write = wr; cmd_len = len; cmd_addr = addr;
        cmd_pci_cmd = pcmd; cmd_rd_be_l = rdbe;
        idx = 0; gapc = 0; stall = 0; subs = 0; cyc = 0; accepted = 0; done = 0;
        while (!done && cyc < 600) begin
            if (stall > 0) begin room = 1'b0; stall--; end
            else room = ($urandom_range(99) < room_pct);
            wr_valid = wr && accepted && idx < n && gapc == 0;
            wr_data  = (idx < n && wr) ? wdat[idx] : $urandom;
            wr_be_l  = (idx < n && wr) ? wbe[idx] : 4'($urandom);
            @(negedge pci_clk);
            if (cmd_valid && cmd_ready) accepted = 1;
            if (wr_valid && wr_ready) begin idx++; gapc = gap; end
            else if (gapc > 0) gapc--;
            if (submit) begin
                subs++;
                if (subs == stall_after) stall = stall_len;
            end
            if (burst_done) done = 1;
            @(posedge pci_clk); #1;
            if (accepted) cmd_valid = 1'b0;
            cyc++;
        end
        cmd_valid = 1'b0; wr_valid = 1'b0; room = 1'b1;
        checks++;
        if (!done) begin
            errors++; $display("FAIL %s timeout: burst_done not seen, got=0 want=1", nm);
        end
        checks++;
        if (obs.size() != exp.size()) begin
            errors++; $display("FAIL %s entry_count: got=%0d want=%0d", nm, obs.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            checks++;
            if (obs[i].t !== exp[i].t || obs[i].c !== exp[i].c || obs[i].d !== exp[i].d || obs[i].bd !== exp[i].bd) begin
                errors++;
                $display("FAIL %s entry[%0d]: got t=%0h c=%0h d=%08h bd=%0b want t=%0h c=%0h d=%08h bd=%0b",
                         nm, i, obs[i].t, obs[i].c, obs[i].d, obs[i].bd, exp[i].t, exp[i].c, exp[i].d, exp[i].bd);
            end
        end
        checks++;
        if (viol_cnt != 0) begin
            errors++; $display("FAIL %s protocol: violations got=%0d want=0", nm, viol_cnt);
        end
        if (chk_consec && obs.size() == exp.size()) begin
            checks++;
            if (obs[obs.size()-1].cyc - obs[1].cyc != n - 1) begin
                errors++;
                $display("FAIL %s consecutive: data span got=%0d want=%0d", nm, obs[obs.size()-1].cyc - obs[1].cyc, n - 1);
            end
        end
        first_cyc = (obs.size() > 0) ? obs[0].cyc : -1;
        last_cyc  = (obs.size() > 0) ? obs[obs.size()-1].cyc : -1;
    endtask

    task automatic test_reset();
        pci_reset_l = 1'b0;
        room = 1'b1; wr_valid = 1'b1; cmd_valid = 1'b1;
        repeat (2) @(posedge pci_clk);
        #1;
        checks++;
        if ({cmd_ready, submit, wr_ready, burst_done, req_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_ctl: got rdy/sub/wrr/bd/err=%b want=10000", {cmd_ready, submit, wr_ready, burst_done, req_err});
        end
        checks++;
        if ({req_type, req_cbe, req_data} !== 39'h0) begin
            errors++; $display("FAIL reset_entry: got t=%0h c=%0h d=%08h want 0", req_type, req_cbe, req_data);
        end
        cmd_valid = 1'b0; wr_valid = 1'b0;
        pci_reset_l = 1'b1;
        @(posedge pci_clk); #1;
    endtask

    task automatic test_basic();
        int f, l;
        run_burst("rd_len1", 1'b0, 4'd1, 32'h0000_1000, 4'h6, 4'h0, 0, -1, 0, 100, 1'b0, f, l);
        fill_wr(3);
        wdat[0] = 32'hA0; wdat[1] = 32'hA1; wdat[2] = 32'hA2;
        wbe[0] = 4'hF; wbe[1] = 4'h0; wbe[2] = 4'h3;
        run_burst("wr_len3", 1'b1, 4'd3, 32'h0000_2004, 4'h7, 4'h0, 0, -1, 0, 100, 1'b1, f, l);
    endtask

    task automatic test_stall();
        int f, l;
        run_burst("wr_stall", 1'b1, 4'd3, 32'h0000_3008, 4'h7, 4'h0, 0, 1, 4, 100, 1'b0, f, l);
        checks++;
        if (obs.size() >= 2 && obs[1].cyc - obs[0].cyc != 5) begin
            errors++; $display("FAIL wr_stall gap: got=%0d want=5", obs[1].cyc - obs[0].cyc);
        end
    endtask

    task automatic test_underrun();
        int f, l;
        fill_wr(2);
        run_burst("wr_gap", 1'b1, 4'd2, 32'h0000_4000, 4'h7, 4'h0, 3, -1, 0, 100, 1'b0, f, l);
        checks++;
        if (obs.size() == 3 && obs[2].cyc - obs[1].cyc != 4) begin
            errors++; $display("FAIL wr_gap spacing: got=%0d want=4", obs[2].cyc - obs[1].cyc);
        end
    endtask

    task automatic test_max_len();
        int f, l;
        run_burst("rd_len16", 1'b0, 4'd0, 32'h0001_0000, 4'h6, 4'h5, 0, -1, 0, 100, 1'b1, f, l);
    endtask

    task automatic test_back_to_back();
        int f1, l1, f2, l2;
        run_burst("b2b_a", 1'b0, 4'd2, 32'h0000_5000, 4'hC, 4'h1, 0, -1, 0, 100, 1'b0, f1, l1);
        fill_wr(2);
        run_burst("b2b_b", 1'b1, 4'd2, 32'h0000_6000, 4'h7, 4'h0, 0, -1, 0, 100, 1'b0, f2, l2);
        checks++;
        if (f2 - l1 != 2) begin
            errors++; $display("FAIL b2b turnaround: got=%0d want=2", f2 - l1);
        end
    endtask

    task automatic test_random();
        int f, l;
        for (int k = 0; k < 8; k++) begin
            logic       wr = 1'($urandom);
            logic [3:0] len = 4'($urandom);
            fill_wr((len == 0) ? 16 : int'(len));
            run_burst($sformatf("rand%0d", k), wr, len, $urandom, 4'($urandom), 4'($urandom),
                      $urandom_range(2), -1, 0, 60, 1'b0, f, l);
        end
    endtask

    task automatic test_reset_mid_burst();
        int subs = 0, cyc = 0;
        fill_wr(8);
        cmd_valid = 1'b1; cmd_is_write = 1'b1; cmd_len = 4'd8; cmd_addr = 32'h0000_7000;
        cmd_pci_cmd = 4'h7; room = 1'b1;
        wr_valid = 1'b1; wr_data = 32'hDEAD_0000; wr_be_l = 4'h0;
        while (subs < 3 && cyc < 50) begin
            @(negedge pci_clk);
            if (submit) subs++;
            @(posedge pci_clk); #1;
            cmd_valid = 1'b0; cyc++;
        end
        checks++;
        if (subs != 3) begin
            errors++; $display("FAIL rst_mid setup: entries got=%0d want=3", subs);
        end
        pci_reset_l = 1'b0;
        #1;
        checks++;
        if ({submit, wr_ready, burst_done, cmd_ready} !== 4'b0001) begin
            errors++; $display("FAIL rst_mid drop: got sub/wrr/bd/rdy=%b want=0001", {submit, wr_ready, burst_done, cmd_ready});
        end
        @(posedge pci_clk); #1;
        wr_valid = 1'b0;
        pci_reset_l = 1'b1;
        cmd_valid = 1'b1; cmd_is_write = 1'b0; cmd_len = 4'd1; cmd_addr = 32'h0000_8000;
        cmd_pci_cmd = 4'h6; cmd_rd_be_l = 4'h9;
        @(negedge pci_clk);
        checks++;
        if (cmd_ready !== 1'b1 || submit !== 1'b0) begin
            errors++; $display("FAIL rst_mid accept: got rdy=%b sub=%b want rdy=1 sub=0", cmd_ready, submit);
        end
        @(posedge pci_clk); #1; cmd_valid = 1'b0;
        @(negedge pci_clk);
        checks++;
        if (submit !== 1'b1 || req_type !== 3'h1 || req_data !== 32'h0000_8000 || req_cbe !== 4'h6) begin
            errors++; $display("FAIL rst_mid addr: got sub=%b t=%0h c=%0h d=%08h want 1/1/6/00008000", submit, req_type, req_cbe, req_data);
        end
        @(negedge pci_clk);
        checks++;
        if (submit !== 1'b1 || req_type !== 3'h3 || req_cbe !== 4'h9 || burst_done !== 1'b1) begin
            errors++; $display("FAIL rst_mid data: got sub=%b t=%0h c=%0h bd=%b want 1/3/9/1", submit, req_type, req_cbe, burst_done);
        end
        @(posedge pci_clk); #1;
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_is_write = 1'b0; cmd_addr = '0; cmd_pci_cmd = '0;
        cmd_len = '0; cmd_rd_be_l = '0; wr_valid = 1'b0; wr_data = '0; wr_be_l = '0;
        room = 1'b1; pci_reset_l = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_underrun();
        test_max_len();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
